// File: rtl/regfile_scoreboard_pkg.sv
// Shared types for the scoreboarded register file: default widths, counter type
// and the read/write bundle structs used around the D and WB stages.
package regfile_scoreboard_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int PEND_W_DEF = 2;

    typedef logic [DATA_W_DEF-1:0] Register;
    typedef logic [ADDR_W_DEF-1:0] RegAddr;
    typedef logic [PEND_W_DEF-1:0] SbCount;

    typedef struct packed {
        RegAddr  addr;
        Register data;
        logic    busy;
    } RF_read;

    typedef struct packed {
        logic    valid;
        RegAddr  dst;
        Register val;
    } RF_write;

endpackage

// File: rtl/regfile_sb_cnt.sv
// Saturating outstanding-write counter for one architectural register.
// A coincident inc/dec pair cancels, so a full counter stays full across it.
module regfile_sb_cnt
    import regfile_scoreboard_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic              busy,
    output logic              full,
    output logic              underflow,
    output logic [PEND_W-1:0] count
);

    assign busy      = (count != '0);
    assign full      = &count;
    assign underflow = dec && !inc && (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + PEND_W'(1);
        end else if (dec && !inc && busy) begin
            count <= count - PEND_W'(1);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register outstanding-write scoreboard for the D stage.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle WB write-through on reads.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dst,
    output logic                     iss_ready,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_dst,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     sb_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PEND_W-1:0] cnt [DEPTH];
    logic [DEPTH-1:0]  busy_vec;
    logic [DEPTH-1:0]  full_vec;
    logic [DEPTH-1:0]  underflow_vec;

    // Register 0 is hard-wired: no counter, never busy, never full, never errors.
    assign cnt[0]           = '0;
    assign busy_vec[0]      = 1'b0;
    assign full_vec[0]      = 1'b0;
    assign underflow_vec[0] = 1'b0;

    for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = iss_valid && (iss_dst == ADDR_W'(r));
        assign dec = wb_valid && (wb_dst == ADDR_W'(r));

        regfile_sb_cnt #(.PEND_W(PEND_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc),
            .dec       (dec),
            .busy      (busy_vec[r]),
            .full      (full_vec[r]),
            .underflow (underflow_vec[r]),
            .count     (cnt[r])
        );
    end

    assign iss_ready = (iss_dst == '0) || !full_vec[iss_dst];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wb_valid && (wb_dst != '0)) begin
            mem[wb_dst] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err <= 1'b0;
        end else if (|underflow_vec) begin
            sb_err <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] port_data;
        logic              port_busy;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            port_data = (addr == '0) ? '0 : mem[addr];
            port_busy = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
            // A write landing this edge retires one pending producer, unless a new one issues alongside.
            if (wb_valid && (addr != '0) && (wb_dst == addr)) begin
                port_data = wb_data;
                if (iss_valid && (iss_dst == addr)) begin
                    port_busy = (cnt[addr] != '0);
                end else begin
                    port_busy = (cnt[addr] > PEND_W'(1));
                end
            end
`endif
        end

        assign rd_data[i*DATA_W +: DATA_W] = port_data;
        assign rd_busy[i]                  = port_busy;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with an integrated write scoreboard, the next-generation replacement for the fixed 2-read, 32×32 register array and the combinational load-use check in decode. Each architectural register carries a saturating outstanding-write counter. Decode reads operands and a per-operand busy flag, which lets the hazard unit stall on any in-flight producer, including variable-latency ones, not just a load in X. Sits in the D stage; the write port is driven from WB.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register address width; depth = 2**ADDR_W
- `NUM_RD`, 2, number of read ports (≥1)
- `PEND_W`, 2, outstanding-write counter width per register (max 2**PEND_W−1 in flight)

Ports:
- `clk` in 1, single clock; all state updates on rising edge
- `reset` in 1, synchronous, active-high
- `rd_addr` in NUM_RD*ADDR_W, read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- `rd_data` out NUM_RD*DATA_W, read data, same packing
- `rd_busy` out NUM_RD, 1 = operand register has a pending write
- `iss_valid` in 1, decode issues an instruction that will write `iss_dst`
- `iss_dst` in ADDR_W, destination of issuing instruction
- `iss_ready` out 1, 0 = `iss_dst` counter saturated; decode must stall
- `wb_valid` in 1, writeback this cycle
- `wb_dst` in ADDR_W, writeback destination
- `wb_data` in DATA_W, writeback value
- `sb_err` out 1, sticky: writeback to a register whose counter was 0

## Operation
- Storage: 2**ADDR_W entries of DATA_W; per-entry counter `cnt[r]` of PEND_W bits.
- Register 0: reads return 0, `rd_busy`=0, writes ignored, issues ignored, never sets `sb_err`; `iss_ready`=1 when `iss_dst`=0.
- Reads are combinational from storage; `rd_busy[i]` = (`cnt[rd_addr_i]` ≠ 0).
- `iss_ready` = (`cnt[iss_dst]` ≠ all-ones) or `iss_dst`=0. Combinational.
- Issue accepted = `iss_valid` & `iss_ready` & `iss_dst`≠0: counter increments at the edge. Issue with `iss_ready`=0 has no effect.
- Writeback (`wb_valid`, `wb_dst`≠0): data written at the edge. The counter decrements if nonzero. If it is 0, data is still written, the counter stays 0, and `sb_err` is set.
- Issue and writeback to the same register in the same cycle: counter unchanged. Data is written.
- Issue and writeback to different registers: both updates apply independently.
- Counters never wrap. Overflow is prevented by `iss_ready`; underflow is prevented by the error rule above.

## Timing
- Reset (edge with `reset`=1): all data entries 0, all counters 0, `sb_err` 0. This takes one cycle and overrides any coincident issue or writeback. After it: `rd_data`=0, `rd_busy`=0, `iss_ready`=1, `sb_err`=0.
- Issue → `rd_busy` visible the cycle after the accepting edge.
- Writeback → data and counter update visible the cycle after the edge, unless bypass is enabled (see Configuration).
- No internal latency on reads; zero-cycle combinational path from `rd_addr` to `rd_data` and `rd_busy`.

## Configuration
- `REGFILE_BYPASS_EN` defined: same-cycle write-through on every read port. Conditions: `wb_valid`, `wb_dst`=`rd_addr_i`≠0. Effects:
  - `rd_data_i`=`wb_data`.
  - `rd_busy_i` = (`cnt`−1 ≠ 0), or `cnt` ≠ 0 when an accepted issue to that register coincides.
  - `cnt`=0 treated as not busy.
- Undefined: reads see only committed state, and WB→D needs one extra stall cycle. `rd_busy` is taken directly from the stored counter.

## Structure
- Shared package additions:
  - `SbCount` typedef, logic[PEND_W-1:0]
  - `RF_read` struct with `addr`, `data`, `busy` fields
  - `RF_write` struct with `valid`, `dst`, `val` fields
  - `RegAddr` and `Register` reused as defaults when `ADDR_W`/`DATA_W` match
- One sub-module: `regfile_sb_cnt`.
  - Per-register saturating up/down counter.
  - Inputs: `inc`, `dec`; outputs: `busy`, `full`, `underflow`.
  - Instantiated 2**ADDR_W−1 times via generate; entry 0 has no counter.

## Test plan
- Reset, then read every address on all ports → `rd_data`=0, `rd_busy`=0, `iss_ready`=1, `sb_err`=0.
- Issue dst=5, then issue dst=5 again, then WB dst=5 data=0xDEADBEEF → busy 1 after first issue; `cnt`=2; after WB `cnt`=1, busy still 1. Second WB → busy 0 and read returns the written value.
- PEND_W=2: issue dst=7 three times → `iss_ready`=0. A fourth issue is ignored and `cnt` stays 3. Simultaneous issue+WB to reg 7 keeps `cnt`=3 and the data is written.
- WB dst=9 with `cnt`=0 → `sb_err`=1 and stays 1 until reset; data 0x12345678 readable next cycle.
- Issue/WB/read on reg 0 with data 0xFFFFFFFF → `rd_data`=0, `rd_busy`=0, no counter change, `sb_err` unchanged.
- With `REGFILE_BYPASS_EN`: `cnt[3]`=1, WB dst=3 data=0xA5A5A5A5 while port 1 reads reg 3 → same cycle `rd_data`=0xA5A5A5A5, `rd_busy`=0. Without the macro: old value and busy=1 that cycle.
